// File: rtl/logic_result_buffer_pkg.sv
// Shared types and constants for the logic-result elastic buffer.
// LOGIC_BUF_ZERO_FLAG_EN selects the reset value of the per-entry zero flag.
package logic_result_buffer_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned TAGW   = 5;
  localparam int unsigned STALLW = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [TAGW-1:0]  rd;
    logic             wen;
    logic             zero;
  } entry_t;

`ifdef LOGIC_BUF_ZERO_FLAG_EN
  localparam logic ZERO_RST = 1'b1;
`else
  localparam logic ZERO_RST = 1'b0;
`endif

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/logic_result_buffer_result_entry_reg.sv
// Load-enabled entry register (result, tag, write enable, zero flag) with async reset.
module result_entry_reg
  import logic_result_buffer_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  entry_t d,
  output entry_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q.y    <= '0;
      q.rd   <= '0;
      q.wen  <= 1'b0;
      q.zero <= ZERO_RST;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/logic_result_buffer.sv
// Two-entry skid buffer between EX logic units and MEM, with flush, zero flag and stall counter.
// Define LOGIC_BUF_ZERO_FLAG_EN to carry a registered out_y==0 flag; otherwise out_zero is 0.
module logic_result_buffer
  import logic_result_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_y,
  input  logic [TAGW-1:0]   in_rd,
  input  logic              in_wen,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_y,
  output logic [TAGW-1:0]   out_rd,
  output logic              out_wen,
  output logic              out_zero,
  output logic [STALLW-1:0] stall_cnt
);

  state_t state_q, state_d;
  logic   accept, handshake;
  logic   load_main, load_skid, main_from_skid;
  entry_t in_entry, main_d, main_q, skid_q;

  assign accept    = in_valid && in_ready && !flush;
  assign handshake = out_valid && out_ready;

  always_comb begin
    in_entry.y   = in_y;
    in_entry.rd  = in_rd;
    in_entry.wen = in_wen;
`ifdef LOGIC_BUF_ZERO_FLAG_EN
    in_entry.zero = is_zero(in_y);
`else
    in_entry.zero = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next state and entry load controls; flush overrides the state only.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && handshake) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (handshake) begin
          state_d   = EMPTY;
        end
      end
      TWO: begin
        if (handshake) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  assign main_d = main_from_skid ? skid_q : in_entry;

  result_entry_reg u_main (
    .clk   (clk),
    .reset (reset),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  result_entry_reg u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (load_skid),
    .d     (in_entry),
    .q     (skid_q)
  );

  // Handshake flags are flopped from the next state so neither depends on out_ready combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d != TWO);
      out_valid <= (state_d != EMPTY);
    end
  end

  assign out_y    = main_q.y;
  assign out_rd   = main_q.rd;
  assign out_wen  = main_q.wen;
  assign out_zero = main_q.zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {STALLW{1'b1}})) begin
      stall_cnt <= stall_cnt + STALLW'(1);
    end
  end

endmodule

// File: tb/tb_logic_result_buffer.sv
// Directed scoreboard bench for logic_result_buffer.
// Honors LOGIC_BUF_ZERO_FLAG_EN when predicting out_zero.
module tb_logic_result_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_y = '0;
  logic [4:0]  in_rd = '0;
  logic        in_wen = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_y;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_zero;
  logic [15:0] stall_cnt;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned model_stall = 0;

`ifdef LOGIC_BUF_ZERO_FLAG_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic_result_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_rd    (out_rd),
    .out_wen   (out_wen),
    .out_zero  (out_zero),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: compare outputs to the model, update the model, advance to the next negedge.
  task automatic tick();
    bit hs, acc;
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
    chk("stall_cnt", 64'(stall_cnt), 64'(model_stall));
    if (sb.size() != 0) begin
      chk("out_y", 64'(out_y), 64'(sb[0].y));
      chk("out_rd", 64'(out_rd), 64'(sb[0].rd));
      chk("out_wen", 64'(out_wen), 64'(sb[0].wen));
      chk("out_zero", 64'(out_zero), 64'(ZF && (sb[0].y == 32'h0)));
    end else if (!ZF) begin
      chk("out_zero_off", 64'(out_zero), 64'(0));
    end
    hs  = (sb.size() != 0) && out_ready;
    acc = in_valid && (sb.size() < 2) && !flush;
    if ((sb.size() != 0) && !out_ready && model_stall < 32'hFFFF) model_stall++;
    if (hs) void'(sb.pop_front());
    if (flush) sb.delete();
    else if (acc) sb.push_back('{y: in_y, rd: in_rd, wen: in_wen});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] y, input logic [4:0] rd, input bit w);
    in_valid = v;
    in_y     = y;
    in_rd    = rd;
    in_wen   = w;
  endtask

  // Hold a result on the input until it is accepted, bounded.
  task automatic push_until(input logic [31:0] y, input logic [4:0] rd);
    int n = 0;
    drive(1'b1, y, rd, 1'b1);
    while (!(in_ready && !flush) && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) begin
      checks++;
      errors++;
      $display("FAIL push_timeout observed=%0d expected<10", n);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_y", 64'(out_y), 64'(0));
    chk("rst_out_rd", 64'(out_rd), 64'(0));
    chk("rst_out_wen", 64'(out_wen), 64'(0));
    chk("rst_out_zero", 64'(out_zero), 64'(ZF));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    sb.delete();
    model_stall = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();

    // Single result, next-cycle latency, then empty
    out_ready = 1'b1;
    drive(1'b1, 32'hF0F0_0F0F, 5'd5, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();

    // Back-pressure: fill both entries, third held off, drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 5'd1, 1'b1); tick();
    drive(1'b1, 32'h2, 5'd2, 1'b0); tick();
    drive(1'b1, 32'h3, 5'd3, 1'b1); tick(); tick();
    out_ready = 1'b1;
    push_until(32'h3, 5'd3);
    repeat (3) tick();

    // Streaming with out_ready held high: no bubbles
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'hA5A5_0000 + 32'(i), 5'(i + 8), i[0]);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    chk("stream_stall_zero", 64'(stall_cnt), 64'(model_stall));

    // Flush from TWO with a valid input that must be dropped
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 5'd11, 1'b1); tick();
    drive(1'b1, 32'h2222_2222, 5'd12, 1'b1); tick();
    drive(1'b1, 32'hDEAD_BEEF, 5'd31, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_4444, 5'd4, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();

    // Zero flag on consecutive results
    drive(1'b1, 32'h0, 5'd1, 1'b1); tick();
    drive(1'b1, 32'h8000_0000, 5'd2, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();

    // Stall counter saturation, survives flush, cleared by reset
    out_ready = 1'b0;
    drive(1'b1, 32'h7777_0000, 5'd7, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0);
    repeat (70000) @(negedge clk);
    model_stall = (model_stall + 70000 > 32'hFFFF) ? 32'hFFFF : model_stall + 70000;
    tick();
    chk("stall_saturated", 64'(stall_cnt), 64'(16'hFFFF));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("stall_after_flush", 64'(stall_cnt), 64'(16'hFFFF));

    // Reset mid-operation with an entry held, then immediate accept
    drive(1'b1, 32'h5555_AAAA, 5'd9, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 32'h0BAD_F00D, 5'd3, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
